fifo_sync_param: RTL and testbench

- Parametrised single-clock FIFO; next generation of the team's 8-bit/16-deep FIFO.
- Width and depth are generic. Overflow policy is selectable (overwrite oldest or drop newest).
- Adds almost-full/almost-empty thresholds, registered read data with valid, synchronous flush, and sticky overflow/underflow error flags.
- Sits between producer and consumer blocks in the same clock domain.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ram.sv | 28 ++
 rtl/fifo_sync_param.sv | 169 ++++++++++++++++
 tb/tb_fifo_sync_param.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO family:
// full-policy encodings and the pointer-width helper.
package fifo_pkg;

  localparam int FIFO_DROP      = 0;
  localparam int FIFO_OVERWRITE = 1;

  // Pointer width for a power-of-two depth (DEPTH >= 2).
  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: one write port and one registered read port, no reset.
// Reading and writing the same address on one edge returns the old word.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [fifo_aw(DEPTH)-1:0]  i_waddr,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_re,
  input  logic [fifo_aw(DEPTH)-1:0]  i_raddr,
  output logic [WIDTH-1:0]           o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with selectable full policy, almost-full/empty
// thresholds, registered read data with valid, flush and sticky error flags.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int OVERWRITE  = FIFO_OVERWRITE,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        wen,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        ren,
  output logic [WIDTH-1:0]            rdata,
  output logic                        rvalid,
  output logic [fifo_aw(DEPTH):0]     count,
  output logic                        full,
  output logic                        empty,
  output logic                        afull,
  output logic                        aempty,
  output logic                        ovf,
  output logic                        udf,
  input  logic                        clr_err
);

  localparam int AW = fifo_aw(DEPTH);
  localparam int CW = AW + 1;

  // Request semantics: wen/ren are single-cycle requests with no back-pressure.
  // A write is taken unless full (policy decides); a read is served when not
  // empty and its word appears on rdata with rvalid exactly one cycle later.

  logic [AW-1:0]    r_waddr;
  logic [AW-1:0]    r_raddr;
  logic [CW-1:0]    r_count;
  logic             r_rvalid;
  logic             r_rd_seen;
  logic             r_ovf;
  logic             r_udf;

  logic             w_full;
  logic             w_empty;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic             w_ovr_adv;
  logic             w_ovf_evt;
  logic             w_udf_evt;
  logic             w_inc;
  logic             w_dec;
  logic [WIDTH-1:0] w_ram_rdata;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  always_comb begin
    w_rd_ok   = 1'b0;
    w_wr_ok   = 1'b0;
    w_ovr_adv = 1'b0;
    w_ovf_evt = 1'b0;
    w_udf_evt = 1'b0;
    if (!flush) begin
      w_rd_ok   = ren && !w_empty;
      w_udf_evt = ren && w_empty;
      w_ovf_evt = wen && w_full && !ren;
      if (!w_full) begin
        w_wr_ok = wen;
      end else if (OVERWRITE == FIFO_OVERWRITE) begin
        w_wr_ok   = wen;
        w_ovr_adv = wen && !ren;
      end else begin
        w_wr_ok = wen && ren;
      end
    end
  end

  // An overwrite while full keeps occupancy at DEPTH, so only a lone write
  // below full increments.
  assign w_inc = w_wr_ok && !w_rd_ok && !w_full;
  assign w_dec = w_rd_ok && !w_wr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waddr   <= '0;
      r_raddr   <= '0;
      r_count   <= '0;
      r_rvalid  <= 1'b0;
      r_rd_seen <= 1'b0;
    end else if (flush) begin
      r_waddr  <= '0;
      r_raddr  <= '0;
      r_count  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_wr_ok) r_waddr <= r_waddr + AW'(1);
      if (w_rd_ok || w_ovr_adv) r_raddr <= r_raddr + AW'(1);
      if (w_inc) r_count <= r_count + CW'(1);
      else if (w_dec) r_count <= r_count - CW'(1);
      r_rvalid <= w_rd_ok;
      if (w_rd_ok) r_rd_seen <= 1'b1;
    end
  end

  // A same-cycle error event takes precedence over clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_evt || (r_ovf && !clr_err);
      r_udf <= w_udf_evt || (r_udf && !clr_err);
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (r_waddr),
    .i_wdata (wdata),
    .i_re    (w_rd_ok),
    .i_raddr (r_raddr),
    .o_rdata (w_ram_rdata)
  );

  // The RAM read register has no reset; rdata reads as zero until the first pop.
  assign rdata  = r_rd_seen ? w_ram_rdata : '0;
  assign rvalid = r_rvalid;
  assign count  = r_count;
  assign full   = w_full;
  assign empty  = w_empty;
  assign afull  = (r_count >= CW'(AFULL_LVL));
  assign aempty = (r_count <= CW'(AEMPTY_LVL));
  assign ovf    = r_ovf;
  assign udf    = r_udf;

`ifdef FORMAL
  logic r_past_ok;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_past_ok <= 1'b0;
    else        r_past_ok <= 1'b1;
  end

  always_comb begin
    if (rst_n) begin
      assert ((r_count == CW'(r_waddr - r_raddr)) ||
              ((r_count == CW'(DEPTH)) && (r_waddr == r_raddr)));
      assert (!(w_full && w_empty));
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && r_past_ok) begin
      assert ((r_count - $past(r_count) <= CW'(1)) || ($past(r_count) - r_count <= CW'(1)) || $past(flush));
      assert (!r_rvalid || $past(ren && !w_empty && !flush));
      cover (w_full);
      cover (w_ovr_adv);
      cover (w_udf_evt);
      cover (flush && !w_empty);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench: two DEPTH=4 FIFOs (overwrite and drop policy) driven by the
// same stimulus, checked against hand-computed values.
module tb_fifo_sync_param;
  import fifo_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             flush = 1'b0;
  logic             wen = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic             ren = 1'b0;
  logic             clr_err = 1'b0;

  logic [WIDTH-1:0] a_rdata, b_rdata;
  logic             a_rvalid, b_rvalid;
  logic [2:0]       a_count, b_count;
  logic             a_full, b_full, a_empty, b_empty;
  logic             a_afull, b_afull, a_aempty, b_aempty;
  logic             a_ovf, b_ovf, a_udf, b_udf;

  fifo_sync_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .OVERWRITE(FIFO_OVERWRITE), .AFULL_LVL(3), .AEMPTY_LVL(2)
  ) u_ovw (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(a_rdata), .rvalid(a_rvalid), .count(a_count), .full(a_full), .empty(a_empty),
    .afull(a_afull), .aempty(a_aempty), .ovf(a_ovf), .udf(a_udf), .clr_err(clr_err)
  );

  fifo_sync_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .OVERWRITE(FIFO_DROP), .AFULL_LVL(3), .AEMPTY_LVL(2)
  ) u_drop (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(b_rdata), .rvalid(b_rvalid), .count(b_count), .full(b_full), .empty(b_empty),
    .afull(b_afull), .aempty(b_aempty), .ovf(b_ovf), .udf(b_udf), .clr_err(clr_err)
  );

  // Scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Driver: apply inputs for one clock, then sample 1 time unit after the edge.
  task automatic cyc(input logic f, input logic w, input logic [WIDTH-1:0] d,
                     input logic r, input logic c);
    flush = f; wen = w; wdata = d; ren = r; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset, then idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",  32'(a_count), 0);
    check("rst_empty",  32'(a_empty), 1);
    check("rst_aempty", 32'(a_aempty), 1);
    check("rst_full",   32'(a_full), 0);
    check("rst_afull",  32'(a_afull), 0);
    check("rst_rvalid", 32'(a_rvalid), 0);
    check("rst_rdata",  32'(a_rdata), 0);
    check("rst_ovf",    32'(a_ovf), 0);
    check("rst_udf",    32'(a_udf), 0);
    rst_n = 1'b1;
    idle();
    check("idle_count", 32'(a_count), 0);
    check("idle_empty", 32'(a_empty), 1);
    check("idle_rvalid", 32'(a_rvalid), 0);

    // Fill with four words and watch the thresholds
    cyc(0, 1, 8'h11, 0, 0);
    check("w1_count", 32'(a_count), 1);
    check("w1_empty", 32'(a_empty), 0);
    cyc(0, 1, 8'h22, 0, 0);
    check("w2_afull", 32'(a_afull), 0);
    check("w2_aempty", 32'(a_aempty), 1);
    cyc(0, 1, 8'h33, 0, 0);
    check("w3_count", 32'(a_count), 3);
    check("w3_afull", 32'(a_afull), 1);
    check("w3_aempty", 32'(a_aempty), 0);
    check("w3_full", 32'(a_full), 0);
    cyc(0, 1, 8'h44, 0, 0);
    check("w4_count", 32'(a_count), 4);
    check("w4_full", 32'(a_full), 1);

    // Drain in order
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, '0, 1, 0);
      check("rd_valid", 32'(a_rvalid), 1);
      check("rd_data", 32'(a_rdata), 32'(exp_q.pop_front()));
    end
    check("rd_empty", 32'(a_empty), 1);
    idle();
    check("rd_idle_valid", 32'(a_rvalid), 0);
    check("rd_hold_data", 32'(a_rdata), 32'h44);

    // Overflow: overwrite policy loses oldest, drop policy loses newest
    for (int i = 1; i <= 4; i++) cyc(0, 1, WIDTH'(i), 0, 0);
    check("of_pre_ovf", 32'(a_ovf), 0);
    cyc(0, 1, 8'h05, 0, 0);
    check("of_ovw_ovf", 32'(a_ovf), 1);
    check("of_ovw_count", 32'(a_count), 4);
    check("of_drop_ovf", 32'(b_ovf), 1);
    check("of_drop_count", 32'(b_count), 4);
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, '0, 1, 0);
      check("of_ovw_data", 32'(a_rdata), 32'(exp_q.pop_front()));
      check("of_drop_data", 32'(b_rdata), 32'(i + 1));
    end
    check("of_ovw_empty", 32'(a_empty), 1);
    check("of_drop_empty", 32'(b_empty), 1);

    // Clear errors, then read+write on empty
    cyc(0, 0, '0, 0, 1);
    check("clr_ovf", 32'(a_ovf), 0);
    check("clr_drop_ovf", 32'(b_ovf), 0);
    cyc(0, 1, 8'hA5, 1, 0);
    check("ud_udf", 32'(a_udf), 1);
    check("ud_count", 32'(a_count), 1);
    check("ud_rvalid", 32'(a_rvalid), 0);
    cyc(0, 0, '0, 1, 0);
    check("ud_rd_valid", 32'(a_rvalid), 1);
    check("ud_rd_data", 32'(a_rdata), 32'hA5);
    cyc(0, 0, '0, 1, 1);
    check("ud_clr_race", 32'(a_udf), 1);
    check("ud_clr_rvalid", 32'(a_rvalid), 0);
    cyc(0, 0, '0, 0, 1);
    check("ud_clr_udf", 32'(a_udf), 0);
    check("ud_clr_ovf", 32'(a_ovf), 0);

    // Flush beats a simultaneous read and write
    cyc(0, 1, 8'h01, 0, 0);
    cyc(0, 1, 8'h02, 0, 0);
    cyc(0, 1, 8'h03, 0, 0);
    check("fl_pre_count", 32'(a_count), 3);
    cyc(1, 1, 8'h77, 1, 0);
    check("fl_count", 32'(a_count), 0);
    check("fl_empty", 32'(a_empty), 1);
    check("fl_rvalid", 32'(a_rvalid), 0);
    check("fl_rdata_hold", 32'(a_rdata), 32'hA5);
    check("fl_waddr", 32'(u_ovw.r_waddr), 0);
    check("fl_raddr", 32'(u_ovw.r_raddr), 0);
    check("fl_udf", 32'(a_udf), 0);
    cyc(0, 1, 8'h5A, 0, 0);
    cyc(0, 0, '0, 1, 0);
    check("fl_after_data", 32'(a_rdata), 32'h5A);
    check("fl_after_count", 32'(a_count), 0);

    // Asynchronous reset in the middle of a burst
    cyc(0, 1, 8'h61, 0, 0);
    cyc(0, 1, 8'h62, 0, 0);
    cyc(0, 0, '0, 1, 0);
    check("ar_pre_valid", 32'(a_rvalid), 1);
    check("ar_pre_data", 32'(a_rdata), 32'h61);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_rvalid", 32'(a_rvalid), 0);
    check("ar_count", 32'(a_count), 0);
    check("ar_empty", 32'(a_empty), 1);
    check("ar_aempty", 32'(a_aempty), 1);
    check("ar_rdata", 32'(a_rdata), 0);
    check("ar_drop_count", 32'(b_count), 0);
    ren = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    check("ar_idle_count", 32'(a_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
